// File: rtl/soundweb_pkg.sv
// Shared constants, field layout and reserved-byte helper for the Soundweb packet decoder.
package soundweb_pkg;

    localparam logic [7:0] STX        = 8'h02;
    localparam logic [7:0] ETX        = 8'h03;
    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;
    localparam logic [7:0] ESC        = 8'h1B;
    localparam logic [7:0] ESC_OFFSET = 8'h80;

    localparam int         BODY_LEN   = 13;
    localparam logic [3:0] IDX_CSUM   = 4'd13;
    localparam logic [3:0] IDX_FULL   = 4'd14;

    localparam int COMMAND = 0;
    localparam int ADDR_0  = 1;
    localparam int ADDR_1  = 2;
    localparam int ADDR_2  = 3;
    localparam int ADDR_3  = 4;
    localparam int ADDR_4  = 5;
    localparam int ADDR_5  = 6;
    localparam int SV_0    = 7;
    localparam int SV_1    = 8;
    localparam int DATA_0  = 9;
    localparam int DATA_1  = 10;
    localparam int DATA_2  = 11;
    localparam int DATA_3  = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BODY   = 2'd1,
        ST_ESCAPE = 2'd2
    } state_t;

    function automatic logic is_reserved_byte(input logic [7:0] b);
        return (b == STX) || (b == ETX) || (b == ACK) || (b == NAK) || (b == ESC);
    endfunction

endpackage

// File: rtl/soundweb_unstuff.sv
// Classifies each raw byte against the current frame state: framing strobes,
// ESC removal with reserved-byte validation, and the recovered logical byte.
module soundweb_unstuff
    import soundweb_pkg::*;
(
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    input  state_t     i_state,
    output logic       o_stx,
    output logic       o_etx,
    output logic       o_esc,
    output logic       o_err,
    output logic       o_ack,
    output logic       o_nak,
    output logic       o_data_valid,
    output logic [7:0] o_data
);

    logic [7:0] w_unesc;
    assign w_unesc = i_byte - ESC_OFFSET;

    // Byte classification for the current state
    always_comb begin
        o_stx        = 1'b0;
        o_etx        = 1'b0;
        o_esc        = 1'b0;
        o_err        = 1'b0;
        o_ack        = 1'b0;
        o_nak        = 1'b0;
        o_data_valid = 1'b0;
        o_data       = i_byte;
        if (i_valid) begin
            case (i_state)
                ST_IDLE: begin
                    o_stx = (i_byte == STX);
                    o_ack = (i_byte == ACK);
                    o_nak = (i_byte == NAK);
                end
                ST_BODY: begin
                    case (i_byte)
                        STX:      o_stx = 1'b1;
                        ETX:      o_etx = 1'b1;
                        ESC:      o_esc = 1'b1;
                        ACK, NAK: o_err = 1'b1;
                        default:  o_data_valid = 1'b1;
                    endcase
                end
                ST_ESCAPE: begin
                    o_data = w_unesc;
                    // A raw STX always restarts; anything else must decode to a reserved byte
                    if (i_byte == STX) begin
                        o_stx = 1'b1;
                    end else if (i_byte == ESC) begin
                        o_err = 1'b1;
                    end else if (is_reserved_byte(w_unesc)) begin
                        o_data_valid = 1'b1;
                    end else begin
                        o_err = 1'b1;
                    end
                end
                default: o_err = 1'b1;
            endcase
        end else begin
            o_data = i_byte;
        end
    end

endmodule

// File: rtl/soundweb_decoder.sv
// Soundweb receive decoder: indexing, XOR checksum and atomic field commit.
// Define SOUNDWEB_ERR_COUNT_EN to add the saturating error_count output.
module soundweb_decoder
    import soundweb_pkg::*;
#(
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] command,
    output logic [7:0] address_0,
    output logic [7:0] address_1,
    output logic [7:0] address_2,
    output logic [7:0] address_3,
    output logic [7:0] address_4,
    output logic [7:0] address_5,
    output logic [7:0] sv_0,
    output logic [7:0] sv_1,
    output logic [7:0] data_0,
    output logic [7:0] data_1,
    output logic [7:0] data_2,
    output logic [7:0] data_3,
    output logic       packet_valid,
    output logic       checksum_error,
    output logic       framing_error,
    output logic       ack_rx,
    output logic       nak_rx
`ifdef SOUNDWEB_ERR_COUNT_EN
    ,
    output logic [ERR_COUNT_WIDTH-1:0] error_count
`endif
);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_idx, w_idx_nxt;
    logic [7:0] r_xor, w_xor_nxt;
    logic [7:0] r_shadow [14];
    logic [7:0] r_fields [BODY_LEN];
    logic       r_pv, r_ce, r_fe, r_ack, r_nak;
    logic       w_pv, w_ce, w_fe, w_store, w_commit;
    logic       w_stx, w_etx, w_esc, w_err, w_ack, w_nak, w_data_valid;
    logic [7:0] w_data;

    soundweb_unstuff u_unstuff (
        .i_valid      (rx_valid),
        .i_byte       (rx_data),
        .i_state      (r_state),
        .o_stx        (w_stx),
        .o_etx        (w_etx),
        .o_esc        (w_esc),
        .o_err        (w_err),
        .o_ack        (w_ack),
        .o_nak        (w_nak),
        .o_data_valid (w_data_valid),
        .o_data       (w_data)
    );

    // Next-state, index/checksum update and pulse decisions
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_xor_nxt   = r_xor;
        w_store     = 1'b0;
        w_commit    = 1'b0;
        w_pv        = 1'b0;
        w_ce        = 1'b0;
        w_fe        = 1'b0;
        if (w_stx) begin
            w_state_nxt = ST_BODY;
            w_idx_nxt   = 4'd0;
            w_xor_nxt   = 8'h00;
            w_fe        = (r_state != ST_IDLE);
        end else if (w_err) begin
            w_fe        = 1'b1;
            w_state_nxt = ST_IDLE;
        end else if (w_esc) begin
            w_state_nxt = ST_ESCAPE;
        end else if (w_etx) begin
            w_state_nxt = ST_IDLE;
            if (r_idx != IDX_FULL) begin
                w_fe = 1'b1;
            end else if (r_xor == r_shadow[IDX_CSUM]) begin
                w_commit = 1'b1;
                w_pv     = 1'b1;
            end else begin
                w_ce = 1'b1;
            end
        end else if (w_data_valid) begin
            // A 15th logical byte overflows the frame
            if (r_idx == IDX_FULL) begin
                w_fe        = 1'b1;
                w_state_nxt = ST_IDLE;
            end else begin
                w_store     = 1'b1;
                w_idx_nxt   = r_idx + 4'd1;
                w_xor_nxt   = (r_idx < IDX_CSUM) ? (r_xor ^ w_data) : r_xor;
                w_state_nxt = ST_BODY;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, shadow buffer, committed fields and registered pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_xor   <= 8'h00;
            r_pv    <= 1'b0;
            r_ce    <= 1'b0;
            r_fe    <= 1'b0;
            r_ack   <= 1'b0;
            r_nak   <= 1'b0;
            for (int i = 0; i < 14; i++) r_shadow[i] <= 8'h00;
            for (int i = 0; i < BODY_LEN; i++) r_fields[i] <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_xor   <= w_xor_nxt;
            r_pv    <= w_pv;
            r_ce    <= w_ce;
            r_fe    <= w_fe;
            r_ack   <= w_ack;
            r_nak   <= w_nak;
            if (w_store) r_shadow[r_idx] <= w_data;
            if (w_commit) begin
                for (int i = 0; i < BODY_LEN; i++) r_fields[i] <= r_shadow[i];
            end
        end
    end

    assign command        = r_fields[COMMAND];
    assign address_0      = r_fields[ADDR_0];
    assign address_1      = r_fields[ADDR_1];
    assign address_2      = r_fields[ADDR_2];
    assign address_3      = r_fields[ADDR_3];
    assign address_4      = r_fields[ADDR_4];
    assign address_5      = r_fields[ADDR_5];
    assign sv_0           = r_fields[SV_0];
    assign sv_1           = r_fields[SV_1];
    assign data_0         = r_fields[DATA_0];
    assign data_1         = r_fields[DATA_1];
    assign data_2         = r_fields[DATA_2];
    assign data_3         = r_fields[DATA_3];
    assign packet_valid   = r_pv;
    assign checksum_error = r_ce;
    assign framing_error  = r_fe;
    assign ack_rx         = r_ack;
    assign nak_rx         = r_nak;

`ifdef SOUNDWEB_ERR_COUNT_EN
    logic [ERR_COUNT_WIDTH-1:0] r_err_count;

    // Saturating count of checksum and framing errors
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if ((w_fe || w_ce) && (r_err_count != '1)) begin
            r_err_count <= r_err_count + {{(ERR_COUNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign error_count = r_err_count;
`endif

endmodule

// File: tb/tb_soundweb_decoder.sv
// Self-checking bench: byte-level behavioural model compared against the decoder every cycle.
module tb_soundweb_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] command, address_0, address_1, address_2, address_3, address_4, address_5;
    logic [7:0] sv_0, sv_1, data_0, data_1, data_2, data_3;
    logic       packet_valid, checksum_error, framing_error, ack_rx, nak_rx;
`ifdef SOUNDWEB_ERR_COUNT_EN
    logic [15:0] error_count;
`endif

    soundweb_decoder dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .command(command), .address_0(address_0), .address_1(address_1),
        .address_2(address_2), .address_3(address_3), .address_4(address_4),
        .address_5(address_5), .sv_0(sv_0), .sv_1(sv_1), .data_0(data_0),
        .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .packet_valid(packet_valid), .checksum_error(checksum_error),
        .framing_error(framing_error), .ack_rx(ack_rx), .nak_rx(nak_rx)
`ifdef SOUNDWEB_ERR_COUNT_EN
        , .error_count(error_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: frame seen as a queue of logical bytes
    bit         m_in_frame, m_esc;
    logic [7:0] m_q[$];
    logic [7:0] m_f[13];
    logic       m_pv, m_ce, m_fe, m_ack, m_nak;
    int         m_err_cnt;
    logic [7:0] fb[13];

    function automatic bit rsv(input logic [7:0] b);
        return (b == 8'h02) || (b == 8'h03) || (b == 8'h06) || (b == 8'h15) || (b == 8'h1B);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0; m_esc = 1'b0; m_q.delete();
        for (int i = 0; i < 13; i++) m_f[i] = 8'h00;
        {m_pv, m_ce, m_fe, m_ack, m_nak} = 5'b0;
        m_err_cnt = 0;
    endtask

    task automatic model_push(input logic [7:0] b);
        if (m_q.size() == 14) begin
            m_fe = 1'b1; m_in_frame = 1'b0;
        end else begin
            m_q.push_back(b);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] ub;
        {m_pv, m_ce, m_fe, m_ack, m_nak} = 5'b0;
        ub = b - 8'h80;
        if (!m_in_frame) begin
            if (b == 8'h02) begin m_in_frame = 1'b1; m_esc = 1'b0; m_q.delete(); end
            else if (b == 8'h06) m_ack = 1'b1;
            else if (b == 8'h15) m_nak = 1'b1;
        end else if (b == 8'h02) begin
            m_fe = 1'b1; m_esc = 1'b0; m_q.delete();
        end else if (m_esc) begin
            m_esc = 1'b0;
            if (b == 8'h1B || !rsv(ub)) begin m_fe = 1'b1; m_in_frame = 1'b0; end
            else model_push(ub);
        end else if (b == 8'h03) begin
            m_in_frame = 1'b0;
            if (m_q.size() == 14) begin
                x = 8'h00;
                for (int i = 0; i < 13; i++) x = x ^ m_q[i];
                if (x == m_q[13]) begin
                    for (int i = 0; i < 13; i++) m_f[i] = m_q[i];
                    m_pv = 1'b1;
                end else m_ce = 1'b1;
            end else m_fe = 1'b1;
        end else if (b == 8'h1B) begin
            m_esc = 1'b1;
        end else if (b == 8'h06 || b == 8'h15) begin
            m_fe = 1'b1; m_in_frame = 1'b0;
        end else begin
            model_push(b);
        end
        if ((m_fe || m_ce) && m_err_cnt < 65535) m_err_cnt++;
    endtask

    function automatic logic [103:0] model_fields();
        logic [103:0] v = '0;
        for (int i = 0; i < 13; i++) v = {v[95:0], m_f[i]};
        return v;
    endfunction

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("fields", {command, address_0, address_1, address_2, address_3, address_4,
                             address_5, sv_0, sv_1, data_0, data_1, data_2, data_3}, model_fields());
            check("pulses", {packet_valid, checksum_error, framing_error, ack_rx, nak_rx},
                  {m_pv, m_ce, m_fe, m_ack, m_nak});
`ifdef SOUNDWEB_ERR_COUNT_EN
            check("error_count", error_count, m_err_cnt[15:0]);
`endif
        end
    end

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            rx_data = 8'($urandom);
            @(posedge clk); #1;
            {m_pv, m_ce, m_fe, m_ack, m_nak} = 5'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        model_byte(b);
        rx_valid = 1'b0;
    endtask

    // Frame from fb: nlog logical bytes (13 body, checksum^cdelta, then 0x55 filler), auto-stuffed
    task automatic send_frame(input int nlog, input logic [7:0] cdelta, input bit with_stx, input bit gaps);
        logic [7:0] cs = 8'h00;
        logic [7:0] lb;
        for (int i = 0; i < 13; i++) cs = cs ^ fb[i];
        if (with_stx) send(8'h02, gaps);
        for (int i = 0; i < nlog; i++) begin
            lb = (i < 13) ? fb[i] : (i == 13) ? (cs ^ cdelta) : 8'h55;
            if (rsv(lb)) begin
                send(8'h1B, gaps);
                send(lb + 8'h80, gaps);
            end else send(lb, gaps);
        end
        send(8'h03, gaps);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; rx_valid = 1'b0;
        model_reset();
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b1;
    endtask

    task automatic set_ref_frame();
        fb = '{8'h88, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h10,
               8'h00, 8'h00, 8'h00, 8'h64};
    endtask

    initial begin
        model_reset();
        chk_en = 1'b1;
        do_reset();
        check("reset_cmd", command, 8'h00);
        idle(2);

        // Clean frame with literal field expectations
        set_ref_frame();
        fb[2] = 8'h22;
        send_frame(14, 8'h00, 1'b1, 1'b0);
        check("clean_pv", packet_valid, 1'b1);
        check("clean_cmd", command, 8'h88);
        check("clean_addr0", address_0, 8'h01);
        check("clean_addr1", address_1, 8'h22);
        check("clean_sv1", sv_1, 8'h10);
        check("clean_data3", data_3, 8'h64);
        idle(2);

        // Reserved bytes in body travel escaped
        set_ref_frame();
        fb[1] = 8'h02;
        send_frame(14, 8'h00, 1'b1, 1'b0);
        check("stuffed_pv", packet_valid, 1'b1);
        check("stuffed_addr0", address_0, 8'h02);
        check("stuffed_addr2", address_2, 8'h03);

        // Bad checksum leaves previous packet intact
        set_ref_frame();
        fb[0] = 8'h77;
        send_frame(14, 8'h01, 1'b1, 1'b0);
        check("csum_err", checksum_error, 1'b1);
        check("csum_hold", command, 8'h88);

        // STX mid-frame restarts the frame
        send(8'h02, 1'b0);
        for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 1'b0);
        send(8'h02, 1'b0);
        check("restart_fe", framing_error, 1'b1);
        send_frame(14, 8'h00, 1'b0, 1'b0);
        check("restart_pv", packet_valid, 1'b1);
        check("restart_cmd", command, 8'h77);

        // Short frame and bad escape
        send_frame(10, 8'h00, 1'b1, 1'b0);
        check("short_fe", framing_error, 1'b1);
        send(8'h02, 1'b0); send(8'h11, 1'b0); send(8'h1B, 1'b0); send(8'h41, 1'b0);
        check("badesc_fe", framing_error, 1'b1);
        check("badesc_hold", command, 8'h77);
        idle(1);

        // Bare ACK/NAK outside a frame
        send(8'h06, 1'b0);
        check("ack", ack_rx, 1'b1);
        send(8'h15, 1'b0);
        check("nak", nak_rx, 1'b1);
        idle(1);

        // Reset mid-frame, then good frame
        send(8'h02, 1'b0); send(8'h33, 1'b0); send(8'h34, 1'b0);
        do_reset();
        check("rst_clear", command, 8'h00);
        set_ref_frame();
        send_frame(14, 8'h00, 1'b1, 1'b0);
        check("post_rst_pv", packet_valid, 1'b1);
        check("post_rst_cmd", command, 8'h88);

`ifdef SOUNDWEB_ERR_COUNT_EN
        do_reset();
        for (int k = 0; k < 3; k++) send_frame(14, 8'h01, 1'b1, 1'b0);
        idle(1);
        check("err_count3", error_count, 16'd3);
`endif

        // Randomized frames, corruptions, gaps and stray bytes
        for (int n = 0; n < 300; n++) begin
            int mode = $urandom_range(0, 9);
            bit gaps = $urandom_range(0, 1) == 1;
            for (int i = 0; i < 13; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 4))
                        0: fb[i] = 8'h02;
                        1: fb[i] = 8'h03;
                        2: fb[i] = 8'h06;
                        3: fb[i] = 8'h15;
                        default: fb[i] = 8'h1B;
                    endcase
                end else fb[i] = 8'($urandom);
            end
            case (mode)
                6: send_frame(14, 8'($urandom_range(1, 255)), 1'b1, gaps);
                7: send_frame($urandom_range(0, 13), 8'h00, 1'b1, gaps);
                8: for (int i = 0; i < $urandom_range(1, 4); i++) send(8'($urandom), gaps);
                9: send_frame(15, 8'h00, 1'b1, gaps);
                default: send_frame(14, 8'h00, 1'b1, gaps);
            endcase
            if ($urandom_range(0, 7) == 0) send(8'($urandom), gaps);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
